// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: field widths, opcode position, HALT opcode, offset sign extension.
package fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int OFF_W   = 6;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 9;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_HALT_DEF = 7'b1101111;

  function automatic logic [ADDR_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    return {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> execute/ROM bus; slave side is the fetch unit, master side drives redirects and ROM data.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               stall;
  logic               br_take;
  logic [OFF_W-1:0]   br_off;
  logic               jmp_take;
  logic [ADDR_W-1:0]  jmp_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic [ADDR_W-1:0]  pc_out;
  logic               halted;

  modport slave (
    input  stall, br_take, br_off, jmp_take, jmp_addr, rom_data,
    output rom_addr, ir, ir_valid, pc_out, halted
  );

  modport master (
    output stall, br_take, br_off, jmp_take, jmp_addr, rom_data,
    input  rom_addr, ir, ir_valid, pc_out, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, jump/branch redirect with flush, stall hold, HALT stop.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [OPC_W-1:0]  OP_HALT  = OP_HALT_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.slave bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               vld_q, vld_d;
  logic               halted_q, halted_d;

  logic is_halt;
  assign is_halt = (bus.rom_data[OPC_MSB:OPC_LSB] == OP_HALT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    halted_d = halted_q;
    if (state_q == S_RUN) begin
      // Redirects only apply to a live instruction in ir.
      if (vld_q && bus.jmp_take) begin
        pc_d  = bus.jmp_addr;
        vld_d = 1'b0;
      end else if (vld_q && bus.br_take) begin
        pc_d  = pc_out_q + sext_off(bus.br_off);
        vld_d = 1'b0;
      end else if (!bus.stall) begin
        ir_d     = bus.rom_data;
        pc_out_d = pc_q;
        vld_d    = 1'b1;
        if (is_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end else begin
      // HALT is presented until execute accepts it once, then nothing more.
      if (!bus.stall) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pc_out_q <= '0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = vld_q;
  assign bus.pc_out   = pc_out_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {ir, pc_out} queued per issued fetch, popped by a monitor.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM model: word = 16'h1000 + addr, with an optional HALT planted at address 16.
  always_comb begin
    if (halt_en && bus.rom_addr == 16'd16) bus.rom_data = 16'hDE00;
    else                                   bus.rom_data = 16'h1000 + bus.rom_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic [15:0] pc);
    exp_q.push_back({ir, pc});
  endtask

  task automatic cyc(input logic st, input logic bt, input logic [5:0] off,
                     input logic jt, input logic [15:0] ja);
    bus.stall    = st;
    bus.br_take  = bt;
    bus.br_off   = off;
    bus.jmp_take = jt;
    bus.jmp_addr = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ir"},       {16'h0, bus.ir},      32'h0);
    chk({tag, "_ir_valid"}, {31'h0, bus.ir_valid}, 32'h0);
    chk({tag, "_pc_out"},   {16'h0, bus.pc_out},  32'h0);
    chk({tag, "_halted"},   {31'h0, bus.halted},  32'h0);
    chk({tag, "_rom_addr"}, {16'h0, bus.rom_addr}, 32'h0);
  endtask

  // Monitor: every cycle execute sees ir_valid must match the next queued fetch.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.ir_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ir_unexpected: got ir=%h pc_out=%h expected no valid instruction",
                   bus.ir, bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ir, bus.pc_out} !== e) begin
            errors++;
            $display("FAIL ir_pc_out: got %h/%h expected %h/%h",
                     bus.ir, bus.pc_out, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    chk_reset("rst0");
    rst = 1'b0;

    // Free-running fetch
    for (int i = 0; i < 4; i++) begin
      push(16'h1000 + 16'(i), 16'(i));
      fetch();
    end
    chk("run_rom_addr", {16'h0, bus.rom_addr}, 32'd4);

    // Stall holds ir/pc_out/pc
    rst = 1'b1; fetch(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(16'h1000 + 16'(i), 16'(i));
      fetch();
    end
    for (int k = 0; k < 3; k++) begin
      push(16'h1002, 16'd2);
      cyc(1'b1, 1'b0, 6'd0, 1'b0, 16'h0);
      chk("stall_rom_addr", {16'h0, bus.rom_addr}, 32'd3);
    end
    push(16'h1003, 16'd3);
    fetch();

    // Jump beats a simultaneous branch
    cyc(1'b0, 1'b1, 6'b111001, 1'b1, 16'd8);
    chk("jmp_prio_rom_addr", {16'h0, bus.rom_addr}, 32'd8);
    chk("jmp_flush", {31'h0, bus.ir_valid}, 32'd0);
    push(16'h1008, 16'd8);
    fetch();

    // Backward branch 8 - 7 = 1
    cyc(1'b0, 1'b1, 6'b111001, 1'b0, 16'h0);
    chk("br_flush", {31'h0, bus.ir_valid}, 32'd0);
    chk("br_rom_addr", {16'h0, bus.rom_addr}, 32'd1);
    push(16'h1001, 16'd1);
    fetch();

    // Jump to top of memory and wrap
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 16'hFFFF);
    push(16'h0FFF, 16'hFFFF);
    fetch();
    chk("wrap_rom_addr", {16'h0, bus.rom_addr}, 32'h0);
    push(16'h1000, 16'h0);
    fetch();

    // Branch wraps downward then upward
    cyc(1'b0, 1'b1, 6'h3F, 1'b0, 16'h0);
    chk("br_wrap_dn", {16'h0, bus.rom_addr}, 32'hFFFF);
    push(16'h0FFF, 16'hFFFF);
    fetch();
    cyc(1'b0, 1'b1, 6'd2, 1'b0, 16'h0);
    chk("br_wrap_up", {16'h0, bus.rom_addr}, 32'h1);

    // Branch ignored while ir_valid = 0
    cyc(1'b1, 1'b1, 6'd5, 1'b0, 16'h0);
    chk("br_ign_stall", {16'h0, bus.rom_addr}, 32'h1);
    push(16'h1001, 16'd1);
    cyc(1'b0, 1'b1, 6'd5, 1'b0, 16'h0);
    chk("br_ign_fetch", {16'h0, bus.rom_addr}, 32'h2);

    // Reset during stall with a valid instruction
    push(16'h1001, 16'd1);
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 16'h0);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 16'h0);
    chk_reset("rst_stall");
    rst = 1'b0;

    // Redirect coinciding with a HALT word on rom_data wins
    halt_en = 1'b1;
    push(16'h1000, 16'd0);
    fetch();
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 16'd15);
    push(16'h100F, 16'd15);
    fetch();
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 16'd16);
    chk("halt_redirect_halted", {31'h0, bus.halted}, 32'd0);
    chk("halt_redirect_vld", {31'h0, bus.ir_valid}, 32'd0);

    // HALT fetched, held through a stall, consumed once, then frozen
    push(16'hDE00, 16'd16);
    fetch();
    chk("halt_halted", {31'h0, bus.halted}, 32'd1);
    chk("halt_rom_addr", {16'h0, bus.rom_addr}, 32'd16);
    push(16'hDE00, 16'd16);
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 16'h0);
    fetch();
    chk("halt_consumed", {31'h0, bus.ir_valid}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, k[0], 6'd3, ~k[0], 16'd40);
      chk("halt_frozen", {bus.rom_addr, 14'h0, bus.halted, bus.ir_valid}, {16'd16, 14'h0, 1'b1, 1'b0});
    end
    rst = 1'b1;
    fetch();
    chk_reset("rst_halt");
    rst = 1'b0;
    push(16'h1000, 16'd0);
    fetch();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter OP_HALT, default 7'b1101111, the opcode (instr[15:9]) that stops fetching.
REQ-003 Parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port stall  input  1  execute stage cannot accept a new instruction this cycle.
REQ-007 Port br_take  input  1  execute resolved a taken relative branch for the instruction in ir.
REQ-008 Port br_off  input  6  two's-complement branch offset, relative to pc_out.
REQ-009 Port jmp_take  input  1  execute requests an absolute jump.
REQ-010 Port jmp_addr  input  16  absolute jump target.
REQ-011 Port rom_data  input  16  instruction word returned by the program ROM for rom_addr.
REQ-012 Port rom_addr  output  16  program ROM address; combinationally equal to the internal pc register.
REQ-013 Port ir  output  16  instruction register presented to execute.
REQ-014 Port ir_valid  output  1  ir holds an instruction execute must consume this cycle.
REQ-015 Port pc_out  output  16  address from which ir was fetched.
REQ-016 Port halted  output  1  a HALT instruction has been fetched; fetching stopped.

Function
REQ-017 State machine SHALL have two states: RUN and HALT; reset enters RUN.
REQ-018 In RUN, per rising edge, exactly one action SHALL occur, priority: rst > jmp_take > br_take > stall > fetch.
REQ-019 Fetch: ir <= rom_data, pc_out <= pc, ir_valid <= 1, pc <= pc + 1; latency from pc to ir is one cycle.
REQ-020 Jump: pc <= jmp_addr, ir_valid <= 0 (flush), ir and pc_out hold.
REQ-021 Branch: pc <= pc_out + sign_extend(br_off) modulo 2^16, ir_valid <= 0 (flush), ir and pc_out hold.
REQ-022 Stall: pc, ir, pc_out, ir_valid all hold.
REQ-023 br_take and jmp_take SHALL be ignored while ir_valid = 0.
REQ-024 pc SHALL wrap 16'hFFFF + 1 -> 16'h0000; branch arithmetic wraps identically in both directions.
REQ-025 Fetch of a word with rom_data[15:9] = OP_HALT: ir <= word, ir_valid <= 1, halted <= 1, pc holds, state <= HALT.
REQ-026 In HALT: ir_valid <= 0 on the first edge with stall = 0 (HALT consumed exactly once), then stays 0; pc, ir, pc_out hold; br_take, jmp_take ignored.
REQ-027 HALT SHALL be left only through rst.
REQ-028 If jmp_take or br_take coincides with a HALT word on rom_data, the redirect wins and halted stays 0.

Reset
REQ-029 With rst = 1 at an edge: pc = RESET_PC, ir = 16'h0000, ir_valid = 0, pc_out = 16'h0000, halted = 0, state = RUN.
REQ-030 Reset mid-operation (including during stall or HALT) SHALL discard all state; first fetch from RESET_PC occurs on the first edge with rst = 0.

Structure
REQ-031 A shared package SHALL hold instruction-field widths, opcode field position [15:9], OP_HALT, and the 6-bit-to-16-bit sign-extension function.
REQ-032 Single module; no sub-module; ROM is external and combinational-read.

Verification
REQ-033 Reset then 4 free-running cycles, ROM[i] = 16'h1000 + i -> ir = 16'h1000..16'h1003 on consecutive cycles, pc_out 0..3, ir_valid = 1 throughout.
REQ-034 stall held 3 cycles with ir = ROM[2] -> ir, pc_out = 2, rom_addr = 3 unchanged; fetch resumes with ROM[3].
REQ-035 ir from pc_out = 8, br_take = 1, br_off = 6'b111001 (-7) -> next cycle ir_valid = 0, rom_addr = 1; following cycle ir = ROM[1], pc_out = 1.
REQ-036 jmp_take = 1, jmp_addr = 16'hFFFF -> fetch from 16'hFFFF, then rom_addr = 16'h0000 (wrap).
REQ-037 ROM[16] = 16'b1101111000000000 -> ir = HALT with ir_valid = 1 one cycle, halted = 1, then ir_valid = 0 and rom_addr frozen at 16 for 20 cycles despite br_take/jmp_take pulses; rst -> rom_addr = 0, halted = 0.
REQ-038 rst asserted during stall with ir_valid = 1 -> all outputs at reset values next cycle; br_take with ir_valid = 0 -> no pc change.
